// File: rtl/ysyx_23060332_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with round-robin tie-break,
// a single outstanding transaction and a watchdog that answers stalled requests.
module ysyx_23060332_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  input  logic              mem_resp_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {M_IFU, M_LSU} master_t;

  state_t           state, state_next;
  master_t          last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_ifu, grant_lsu;
  logic             complete, expire;
  logic [DATA_W-1:0] resp_rdata;
  logic             resp_err;

  // On a tie the master that did not win last time is granted.
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant == M_IFU);
  assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant == M_LSU);

  assign complete = (state == ST_WAIT) && mem_resp_valid;
  // A response arriving in the last allowed cycle beats the watchdog.
  assign expire   = (TIMEOUT != 0) && (state != ST_IDLE) && (cnt == CNT_LAST) && !complete;

  assign resp_rdata = (complete && !mem_req_wen) ? mem_resp_rdata : '0;
  assign resp_err   = complete ? mem_resp_err : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (grant_ifu || grant_lsu) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (expire)             state_next = ST_IDLE;
        else if (mem_req_ready) state_next = ST_WAIT;
      end
      ST_WAIT:  if (complete || expire) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = (state == ST_ISSUE);
    if (state == ST_IDLE && !rst) begin
      ifu_req_ready = grant_ifu;
      lsu_req_ready = grant_lsu;
    end
  end

  // NOTE: the latched request fields are plain registers, not a memory, so
  // they are reset to give the memory port defined zeros after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= M_IFU;
      cnt            <= '0;
      mem_req_addr   <= '0;
      mem_req_wen    <= 1'b0;
      mem_req_wdata  <= '0;
      mem_req_wmask  <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_rdata <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_rdata <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (grant_lsu) begin
          last_grant    <= M_LSU;
          cnt           <= '0;
          mem_req_addr  <= lsu_req_addr;
          mem_req_wen   <= lsu_req_wen;
          mem_req_wdata <= lsu_req_wdata;
          mem_req_wmask <= lsu_req_wmask;
        end else if (grant_ifu) begin
          last_grant    <= M_IFU;
          cnt           <= '0;
          mem_req_addr  <= ifu_req_addr;
          mem_req_wen   <= 1'b0;
          mem_req_wdata <= '0;
          mem_req_wmask <= '0;
        end
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (complete || expire) begin
          if (last_grant == M_IFU) begin
            ifu_resp_valid <= 1'b1;
            ifu_resp_rdata <= resp_rdata;
            ifu_resp_err   <= resp_err;
          end else begin
            lsu_resp_valid <= 1'b1;
            lsu_resp_rdata <= resp_rdata;
            lsu_resp_err   <= resp_err;
          end
        end
      end
    end
  end

endmodule

// File: doc/ysyx_23060332_mem_arbiter.md
Name: ysyx_23060332_mem_arbiter

Overview:
Two-master, one-slave arbiter sharing the single memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle core. It accepts one request at a time, forwards it to memory over a valid/ready handshake, and routes the response back to the requester. Ties are resolved round-robin, and a watchdog returns an error if memory stalls. It sits between the pc/idu fetch path, the exu memory access path and the memory module, with one transaction outstanding at a time.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MASK_W, 8, write byte-mask width (DATA_W/8)
TIMEOUT, 255, maximum cycles in ISSUE+WAIT before an error response; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  one-cycle pulse: IFU response valid
ifu_resp_rdata  out  DATA_W  IFU read data
ifu_resp_err  out  1  IFU error (slave error or timeout)
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_W  LSU address
lsu_req_wen  in  1  1=write, 0=read
lsu_req_wdata  in  DATA_W  write data
lsu_req_wmask  in  MASK_W  write byte mask
lsu_resp_valid  out  1  one-cycle pulse: LSU response valid
lsu_resp_rdata  out  DATA_W  LSU read data (0 for writes)
lsu_resp_err  out  1  LSU error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  latched address
mem_req_wen  out  1  latched write enable
mem_req_wdata  out  DATA_W  latched write data
mem_req_wmask  out  MASK_W  latched mask
mem_resp_valid  in  1  memory response valid
mem_resp_rdata  in  DATA_W  memory read data
mem_resp_err  in  1  memory error

Behaviour:
- Reset is synchronous and active-high, on clk. Reset state: state=IDLE, last_grant=IFU, timeout counter=0.
- Reset values: all *_resp_valid/err/rdata=0, mem_req_valid=0, mem_req_* fields=0.
- Reset mid-transaction aborts it. No response is delivered for the aborted request.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - *_req_ready is combinational and is high only in IDLE, only for the granted master, and never while rst=1.
  - Only one master valid: grant that master.
  - Both valid: grant the master that is not last_grant. From reset, the LSU therefore wins the first tie.
- IDLE, on grant: latch addr/wen/wdata/wmask, record grant in last_grant, clear the counter, go to ISSUE.
  - IFU grants force wen=0, wdata=0, wmask=0.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready: mem_req_valid drops next cycle, go to WAIT.
- WAIT:
  - On mem_resp_valid: register rdata/err into the granted master's resp outputs. The matching resp_valid is high for exactly the next cycle, and the state returns to IDLE in that same cycle.
  - A write response returns rdata=0 to the master regardless of mem_resp_rdata.
- mem_resp_valid outside WAIT (including a response in the accept cycle, or a late response after timeout) is ignored. Slaves must respond at least 1 cycle after accept.
- Watchdog:
  - Counter increments every cycle in ISSUE or WAIT. Width is clog2(TIMEOUT+1), saturating.
  - When it reaches TIMEOUT with no completion: respond to the granted master with err=1, rdata=0, drop mem_req_valid, go to IDLE.
  - If completion and timeout coincide, completion wins.
- Back-to-back: a new grant is allowed in the same IDLE cycle in which the previous resp_valid pulses.
- Minimum latency: accept at T (IDLE), mem_req_valid at T+1, ready at T+1, WAIT at T+2, mem_resp at T+2, master resp_valid at T+3.
- Masters have no response back-pressure and must sample resp in the pulse cycle. Only the granted master's resp_valid ever asserts.

Test Plan:
- Single IFU read: addr=0x80000000, mem ready immediately, resp rdata=0x0000_0013_0000_0013 at T+2 -> ifu_resp_valid at T+3 with that data, err=0; lsu_resp_valid stays 0.
- LSU write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held low 3 cycles -> mem_req_* fields stable throughout, lsu_resp_valid with rdata=0.
- Simultaneous valid from reset, both held -> grants alternate LSU, IFU, LSU, IFU; exactly one req_ready per IDLE cycle.
- TIMEOUT=4, mem never responds -> resp err=1, rdata=0 exactly 4 cycles after entering ISSUE. A late mem_resp_valid is ignored, and the next request completes normally.
- mem_resp_err=1 on an LSU read -> lsu_resp_err=1 for one cycle, FSM back to IDLE.
- rst asserted during WAIT, then mem_resp_valid -> no resp_valid pulse; all outputs 0; the next IFU request is accepted normally.
